// File: rtl/mdu_if.sv
// -----------------------------------------------------------------------------
// mdu_if -- EX-stage / hazard-unit connection to the multiply/divide controller.
//
// Signals (master = EX stage / hazard unit side, slave = mdu_ctrl):
//   start      master->slave  EX stage holds a valid MD operation this cycle
//   op         master->slave  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   rs_val     master->slave  forwarded GPR[rs]
//   rt_val     master->slave  forwarded GPR[rt]
//   md_use_d   master->slave  D stage holds an MD-class instruction
//   busy       slave->master  multi-cycle operation in progress
//   stall_req  slave->master  hold the MD-class instruction in D
//   done       slave->master  one-cycle pulse when HI/LO take a new result
//   hi, lo     slave->master  architectural HI/LO registers
// -----------------------------------------------------------------------------
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_d;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, md_use_d,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, md_use_d,
        output busy, stall_req, done, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller for the pipelined MIPS core.
//
// Owns the HI/LO registers. A mult/div result is computed in the cycle the
// operation is accepted, parked in pending registers, and released to HI/LO
// after a fixed busy period that models the latency of the iterative resource.
// mthi/mtlo write HI/LO directly with single-cycle latency.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-low reset
//   md     mdu_if.slave: start/op/rs_val/rt_val/md_use_d in,
//          busy/stall_req/done/hi/lo out
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu  (>= 1)
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               done_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        pend_hi_p1;
    logic [31:0]        pend_lo_p1;

    logic signed [63:0] a_s_p0;
    logic signed [63:0] b_s_p0;
    logic signed [63:0] prod_s_p0;
    logic [63:0]        prod_u_p0;
    logic [63:0]        sdiv_p0;
    logic [63:0]        udiv_p0;
    logic [31:0]        res_hi_p0;
    logic [31:0]        res_lo_p0;
    logic               is_md_op;

    // Signed divide via magnitudes so the 0x80000000 / -1 overflow case falls
    // out naturally as quotient 0x80000000, remainder 0. Returns {rem, quo}.
    function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        ua = a[31] ? (32'd0 - a) : a;
        ub = b[31] ? (32'd0 - b) : b;
        if (ub == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (a[31] ^ b[31]) q = 32'd0 - q;
        if (a[31])         r = 32'd0 - r;
        return {r, q};
    endfunction

    // Unsigned divide, returns {rem, quo}; zero divisor handled by caller.
    function automatic logic [63:0] udiv(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
    endfunction

    // Stage p0: result of the operation presented on the EX-stage inputs
    assign a_s_p0    = {{32{md.rs_val[31]}}, md.rs_val};
    assign b_s_p0    = {{32{md.rt_val[31]}}, md.rt_val};
    assign prod_s_p0 = a_s_p0 * b_s_p0;
    assign prod_u_p0 = {32'd0, md.rs_val} * {32'd0, md.rt_val};
    assign sdiv_p0   = sdiv(md.rs_val, md.rt_val);
    assign udiv_p0   = udiv(md.rs_val, md.rt_val);
    assign is_md_op  = ~md.op[2];

    always_comb begin
        // Divide by zero rewrites HI/LO with their current contents.
        res_hi_p0 = hi_q;
        res_lo_p0 = lo_q;
        case (md.op)
            OP_MULT: begin
                res_hi_p0 = prod_s_p0[63:32];
                res_lo_p0 = prod_s_p0[31:0];
            end
            OP_MULTU: begin
                res_hi_p0 = prod_u_p0[63:32];
                res_lo_p0 = prod_u_p0[31:0];
            end
            OP_DIV: begin
                if (md.rt_val != 32'd0) begin
                    res_hi_p0 = sdiv_p0[63:32];
                    res_lo_p0 = sdiv_p0[31:0];
                end
            end
            OP_DIVU: begin
                if (md.rt_val != 32'd0) begin
                    res_hi_p0 = udiv_p0[63:32];
                    res_lo_p0 = udiv_p0[31:0];
                end
            end
            default: begin
                res_hi_p0 = hi_q;
                res_lo_p0 = lo_q;
            end
        endcase
    end

    // Stage p1: pending result held while the busy period counts down
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            done_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_hi_p1 <= 32'd0;
            pend_lo_p1 <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (md.start) begin
                        if (is_md_op) begin
                            pend_hi_p1 <= res_hi_p0;
                            pend_lo_p1 <= res_lo_p0;
                            cnt        <= md.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state      <= RUN;
                        end else if (md.op == OP_MTHI) begin
                            hi_q <= md.rs_val;
                        end else if (md.op == OP_MTLO) begin
                            lo_q <= md.rs_val;
                        end
                    end
                end
                RUN: begin
                    // Any start while running is dropped; hazard unit normally prevents it.
                    if (cnt == CNT_W'(1)) begin
                        hi_q   <= pend_hi_p1;
                        lo_q   <= pend_lo_p1;
                        done_q <= 1'b1;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign md.busy      = (state == RUN);
    assign md.done      = done_q;
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
    // Stall also covers the accept cycle so the next MD instruction in D waits.
    assign md.stall_req = md.md_use_d & ((state == RUN) | (md.start & is_md_op));

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl (default parameters).
// A cycle-indexed reference model tracks when results land and checks every
// output each cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    mdu_if bus ();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    bit          m_en = 0;
    bit          m_active = 0;
    int          m_end = 0;
    int          m_done_cyc = -1;
    logic [31:0] m_hi = 0, m_lo = 0, m_ph = 0, m_pl = 0;

    function automatic void compute(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] chi, input logic [31:0] clo,
                                    output logic [31:0] ph, output logic [31:0] pl);
        longint      sa, sb, q, r;
        logic [63:0] p;
        ph = chi;
        pl = clo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin p = sa * sb; ph = p[63:32]; pl = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; ph = p[63:32]; pl = p[31:0]; end
            3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; pl = q[31:0]; ph = r[31:0]; end
            3'd3: if (b != 0) begin pl = a / b; ph = a % b; end
            default: ;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_en = 1; m_active = 0; m_done_cyc = -1;
            m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0;
        end else if (!m_active && bus.start) begin
            if (bus.op <= 3) begin
                compute(bus.op, bus.rs_val, bus.rt_val, m_hi, m_lo, m_ph, m_pl);
                m_active = 1;
                m_end = cyc + ((bus.op >= 2) ? DC : MC) + 1;
            end else if (bus.op == 4) m_hi = bus.rs_val;
            else if (bus.op == 5) m_lo = bus.rs_val;
        end
        cyc++;
        if (m_active && cyc == m_end) begin
            m_hi = m_ph; m_lo = m_pl; m_active = 0; m_done_cyc = cyc;
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            chk("m_busy", 32'(bus.busy), 32'(m_active));
            chk("m_done", 32'(bus.done), 32'(m_done_cyc == cyc));
            chk("m_hi", bus.hi, m_hi);
            chk("m_lo", bus.lo, m_lo);
            chk("m_stall", 32'(bus.stall_req),
                32'(bus.md_use_d & (m_active | (bus.start & (bus.op <= 3)))));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input bit hazard,
                          output int nbusy, output int nstall);
        bit got_done;
        bus.start = 1; bus.op = o; bus.rs_val = a; bus.rt_val = b; bus.md_use_d = use_d;
        #1;
        nstall = bus.stall_req ? 1 : 0;
        step();
        bus.start = 0; bus.op = 0;
        nbusy = 0;
        got_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (hazard && i == 1) begin
                bus.start = 1; bus.op = 3'd2; bus.rs_val = 100; bus.rt_val = 3;
            end else if (hazard && i == 2) begin
                bus.start = 1; bus.op = 3'd5; bus.rs_val = 32'hDEAD_BEEF;
            end else begin
                bus.start = 0;
            end
            #1;
            if (bus.done) begin
                got_done = 1;
                break;
            end
            if (bus.busy) nbusy++;
            if (bus.stall_req) nstall++;
            step();
        end
        chk("done_seen", 32'(got_done), 32'd1);
        chk("stall_at_done", 32'(bus.stall_req), 32'd0);
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        bus.start = 0;
        bus.md_use_d = 0;
    endtask

    int nb, ns, ndone;

    initial begin
        reset = 0;
        bus.start = 1; bus.op = 0; bus.rs_val = 32'h1234; bus.rt_val = 32'h5;
        bus.md_use_d = 0;
        step(); step();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        bus.start = 0;
        reset = 1;
        step(); step(); step();
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_hi", bus.hi, 0);
        chk("post_rst_lo", bus.lo, 0);

        // mult -1 * 3 with D-stage MD instruction stalled throughout
        run_op(3'd0, 32'hFFFF_FFFF, 32'h3, 1'b1, 0, nb, ns);
        chk("mult_busy_cycles", nb, MC);
        chk("mult_stall_cycles", ns, MC + 1);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFD);
        step();
        chk("mult_done_single", 32'(bus.done), 0);

        // multu same operands, no stall demand
        run_op(3'd1, 32'hFFFF_FFFF, 32'h3, 1'b0, 0, nb, ns);
        chk("multu_stall_cycles", ns, 0);
        chk("multu_hi", bus.hi, 32'h0000_0002);
        chk("multu_lo", bus.lo, 32'hFFFF_FFFD);

        // back-to-back: div -7 / 2 started in the done cycle
        run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b0, 0, nb, ns);
        chk("div_busy_cycles", nb, DC);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        // divu by zero: HI/LO unchanged
        run_op(3'd3, 32'h7, 32'h0, 1'b0, 0, nb, ns);
        chk("divz_busy_cycles", nb, DC);
        chk("divz_hi", bus.hi, 32'hFFFF_FFFF);
        chk("divz_lo", bus.lo, 32'hFFFF_FFFD);

        // overflow divide
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, nb, ns);
        chk("divovf_lo", bus.lo, 32'h8000_0000);
        chk("divovf_hi", bus.hi, 32'h0000_0000);

        // divu regular
        run_op(3'd3, 32'd100, 32'd7, 1'b0, 0, nb, ns);
        chk("divu_lo", bus.lo, 32'd14);
        chk("divu_hi", bus.hi, 32'd2);

        // starts during RUN are dropped
        run_op(3'd0, 32'd5, 32'd7, 1'b1, 1, nb, ns);
        chk("hazard_busy_cycles", nb, MC);
        chk("hazard_hi", bus.hi, 32'd0);
        chk("hazard_lo", bus.lo, 32'd35);

        // mthi after done
        bus.start = 1; bus.op = 3'd4; bus.rs_val = 32'h1234_5678;
        step();
        bus.start = 0;
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        chk("mthi_busy", 32'(bus.busy), 0);
        chk("mthi_done", 32'(bus.done), 0);

        // op 6 is a no-op
        bus.start = 1; bus.op = 3'd6; bus.rs_val = 32'hAAAA_AAAA;
        step();
        bus.start = 0;
        chk("nop_busy", 32'(bus.busy), 0);
        chk("nop_hi", bus.hi, 32'h1234_5678);
        chk("nop_lo", bus.lo, 32'd35);

        // reset in busy cycle 4 of a div
        bus.start = 1; bus.op = 3'd2; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
        step();
        bus.start = 0;
        step(); step(); step();
        chk("midrst_busy_before", 32'(bus.busy), 1);
        reset = 0;
        step();
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_hi", bus.hi, 0);
        chk("midrst_lo", bus.lo, 0);
        reset = 1;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus.done) ndone++;
            step();
        end
        chk("midrst_no_done", ndone, 0);
        chk("midrst_hi_after", bus.hi, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo operations from the EX stage and owns the HI/LO architectural registers. It models the fixed multi-cycle latency of the multiply and divide resource. While that resource is occupied, it generates the stall request the hazard unit uses to hold any MD-class instruction in the D stage.

## Interface

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
- start  input  1  EX stage holds a valid MD operation this cycle
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 treated as no-op
- rs_val  input  32  forwarded GPR[rs] (dividend / multiplicand / mthi-mtlo source)
- rt_val  input  32  forwarded GPR[rt] (divisor / multiplier)
- md_use_d  input  1  D stage holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  output  1  multi-cycle operation in progress
- stall_req  output  1  combinational: md_use_d & (busy | (start & op ≤ 3))
- done  output  1  one-cycle pulse in the first cycle HI/LO hold a new mult/div result
- hi  output  32  HI register (mfhi source)
- lo  output  32  LO register (mflo source)

## Operation

- States: IDLE (count = 0) and RUN (count ≠ 0). busy = (count ≠ 0).
- IDLE, start, op ∈ {0..3}:
  - Latch the computed result into pending_hi/pending_lo.
  - Load count with MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3).
  - Enter RUN.
- Operation results:
  - mult: {hi,lo} = $signed(rs_val) * $signed(rt_val), 64-bit.
  - multu: unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient in lo, unsigned remainder in hi.
- Special cases:
  - Divide by zero (rt_val = 0): a full busy period elapses, done pulses, and HI/LO are rewritten with their current values (architecturally unchanged).
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. No trap.
- IDLE, start, op 4/5: hi (op 4) or lo (op 5) = rs_val at the next edge. Single cycle; busy stays 0; no done pulse.
- RUN: count decrements each cycle. On the edge where count goes 1→0, hi/lo ← pending_hi/pending_lo, and done = 1 for the following cycle.
- start while busy = 1 is ignored entirely (no state change). The hazard unit prevents this; the bench still checks it.
- op 6/7 with start: no effect.
- reset = 0 at an edge:
  - count = 0, busy = 0, done = 0.
  - hi = 0, lo = 0.
  - pending registers cleared.
  - This applies mid-RUN too: the in-flight result is discarded.

## Timing

- Reset values: busy 0, done 0, hi 0x00000000, lo 0x00000000. stall_req follows its equation (0 unless md_use_d & start & op ≤ 3).
- start sampled at the edge ending cycle T (mult/div):
  - busy = 1 in cycles T+1 … T+N, with N = MULT_CYCLES or DIV_CYCLES.
  - hi/lo show the new value from cycle T+N+1.
  - done = 1 in cycle T+N+1 only.
  - busy = 0 in cycle T+N+1.
- Back-to-back: a new start is accepted in cycle T+N+1 (busy = 0), giving the next result at T+2N+2.
- stall_req is 1 in cycle T (start & md_use_d) and in T+1 … T+N whenever md_use_d = 1. It is 0 in T+N+1, so an mfhi in D during T+N+1 reads the updated hi.
- mthi/mtlo: new value visible in the cycle after the start edge; latency 1.
- No combinational path from hi/lo to any input; stall_req is the only combinational output.

## Test plan

- Reset: hold reset = 0 for 2 cycles with start = 1, op = 0 -> busy 0, hi 0, lo 0, done 0; release -> all remain 0 until a new start.
- mult rs = 0xFFFFFFFF (−1), rt = 0x00000003 -> busy high exactly 5 cycles; then hi = 0xFFFFFFFF, lo = 0xFFFFFFFD; done a single pulse. multu with the same operands -> hi = 0x00000002, lo = 0xFFFFFFFD.
- div rs = 0xFFFFFFF9 (−7), rt = 2 -> busy exactly 10 cycles; lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu rs = 7, rt = 0 -> hi/lo unchanged after 10 busy cycles; done pulses.
- Stall: md_use_d = 1 throughout a mult -> stall_req = 1 from the start cycle through the last busy cycle, then 0. md_use_d = 0 -> stall_req = 0 throughout.
- Hazard: start op 2 during RUN of a mult, plus mtlo during RUN -> both ignored; final hi/lo equal the mult result. After done, mthi rs = 0x12345678 -> hi = 0x12345678 the next cycle; busy stays 0.
- Reset mid-operation: div started, reset = 0 at busy cycle 4 -> busy 0, hi/lo 0, no done pulse afterwards.
